// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus a WIDTH-cycle
// shift-add multiplier, with a 2*WIDTH registered result and zero/error flags.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           opcode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 zero,
   output logic                 err
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned RW    = 2 * WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_MUL  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_XNOR = 4'b1000;
   localparam logic [3:0] OP_SHL  = 4'b1001;
   localparam logic [3:0] OP_SHR  = 4'b1010;
   localparam logic [3:0] OP_CAT  = 4'b1011;

   logic [0:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [RW-1:0]    mcand, mcand_n;
   logic [WIDTH-1:0] mplier, mplier_n;
   logic [RW-1:0]    acc, acc_n, acc_step;
   logic             busy_n, done_n, zero_n, err_n;
   logic [RW-1:0]    result_n;

   logic [WIDTH:0]   add_v, sub_v;
   logic [WIDTH-1:0] logic_v;
   logic [RW-1:0]    alu_val;
   logic             alu_valid;

   // Single-cycle datapath; narrow intermediates keep upper result bits zero
   always_comb begin
      add_v     = {1'b0, a} + {1'b0, b};
      sub_v     = {1'b0, a} - {1'b0, b};
      logic_v   = '0;
      alu_val   = '0;
      alu_valid = 1'b1;
      case (opcode)
         OP_ADD:  alu_val = RW'(add_v);
         OP_SUB:  alu_val = RW'(sub_v);
         OP_AND:  begin logic_v = a & b;    alu_val = RW'(logic_v); end
         OP_OR:   begin logic_v = a | b;    alu_val = RW'(logic_v); end
         OP_XOR:  begin logic_v = a ^ b;    alu_val = RW'(logic_v); end
         OP_NAND: begin logic_v = ~(a & b); alu_val = RW'(logic_v); end
         OP_NOR:  begin logic_v = ~(a | b); alu_val = RW'(logic_v); end
         OP_XNOR: begin logic_v = ~(a ^ b); alu_val = RW'(logic_v); end
         OP_SHL:  alu_val = RW'({a, 1'b0});
         OP_SHR:  begin logic_v = a >> 1;   alu_val = RW'(logic_v); end
         OP_CAT:  alu_val = {a, b};
         default: alu_valid = 1'b0;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      acc_n    = acc;
      busy_n   = busy;
      done_n   = 1'b0;
      result_n = result;
      zero_n   = zero;
      err_n    = err;
      acc_step = acc + (mplier[0] ? mcand : '0);
      case (state)
         S_IDLE: begin
            if (start) begin
               if (opcode == OP_MUL) begin
                  state_n  = S_MUL;
                  mcand_n  = RW'(a);
                  mplier_n = b;
                  acc_n    = '0;
                  cnt_n    = '0;
                  busy_n   = 1'b1;
                  err_n    = 1'b0;
               end else if (alu_valid) begin
                  result_n = alu_val;
                  zero_n   = (alu_val == '0);
                  err_n    = 1'b0;
                  done_n   = 1'b1;
               end else begin
                  err_n    = 1'b1;
                  done_n   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_n    = acc_step;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               result_n = acc_step;
               zero_n   = (acc_step == '0);
               done_n   = 1'b1;
               busy_n   = 1'b0;
               cnt_n    = '0;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
         acc    <= acc_n;
         busy   <= busy_n;
         done   <= done_n;
         result <= result_n;
         zero   <= zero_n;
         err    <= err_n;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_alu_seq;

   localparam int unsigned W  = 8;
   localparam int unsigned RW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    opcode = 4'd0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done, zero, err;
   logic [RW-1:0] result;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic for the single-cycle opcodes
   function automatic logic [RW-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y, output bit valid);
      longint ux = longint'(x);
      longint uy = longint'(y);
      longint mw = (longint'(1) << W) - 1;
      longint r  = 0;
      valid = 1'b1;
      case (op)
         4'd0:  r = ux + uy;
         4'd2:  r = (ux - uy) & ((longint'(1) << (W + 1)) - 1);
         4'd3:  r = ux & uy;
         4'd4:  r = ux | uy;
         4'd5:  r = ux ^ uy;
         4'd6:  r = (~(ux & uy)) & mw;
         4'd7:  r = (~(ux | uy)) & mw;
         4'd8:  r = (~(ux ^ uy)) & mw;
         4'd9:  r = ux * 2;
         4'd10: r = ux / 2;
         4'd11: r = ux * (longint'(1) << W) + uy;
         default: valid = 1'b0;
      endcase
      return RW'(r);
   endfunction

   logic [RW-1:0] m_r;
   bit            m_v;
   always_comb m_r = ref_op(opcode, a, b, m_v);

   // Transaction-level model: one op in flight, multiply completes W edges later
   logic          m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b0, m_err = 1'b0;
   logic [RW-1:0] m_result = '0, m_prod = '0;
   int            m_rem = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_zero <= 1'b0; m_err <= 1'b0;
         m_result <= '0; m_prod <= '0; m_rem <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_busy   <= 1'b0;
               m_done   <= 1'b1;
               m_result <= m_prod;
               m_zero   <= (m_prod == '0);
            end
         end else if (start) begin
            if (opcode == 4'd1) begin
               m_busy <= 1'b1;
               m_rem  <= W;
               m_prod <= RW'(longint'(a) * longint'(b));
               m_err  <= 1'b0;
            end else begin
               m_done <= 1'b1;
               if (m_v) begin
                  m_result <= m_r;
                  m_zero   <= (m_r == '0);
                  m_err    <= 1'b0;
               end else begin
                  m_err <= 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run && !rst) begin
         check("model_busy",   longint'(busy),   longint'(m_busy));
         check("model_done",   longint'(done),   longint'(m_done));
         check("model_result", longint'(result), longint'(m_result));
         check("model_zero",   longint'(zero),   longint'(m_zero));
         check("model_err",    longint'(err),    longint'(m_err));
      end
   end

   task automatic issue_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1; opcode = op; a = x; b = y;
      @(negedge clk);
      start = 1'b0;
   endtask

   logic [RW-1:0] vec_exp [9] = '{16'h0042, 16'h00DB, 16'h0099, 16'h00BD, 16'h0024,
                                  16'h0066, 16'h0186, 16'h0061, 16'hC35A};

   initial begin
      int n;
      int dcount;
      #1 rst = 1'b1;
      #20;
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      check("reset_result", longint'(result), 0);
      check("reset_busy", longint'(busy), 0);

      issue_op(4'd0, 8'd200, 8'd100);
      check("add_done", longint'(done), 1);
      check("add_result", longint'(result), 16'h012C);
      check("add_zero", longint'(zero), 0);
      check("add_err", longint'(err), 0);
      @(negedge clk);
      check("add_done_clear", longint'(done), 0);

      // Asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      check("async_rst_result", longint'(result), 0);
      check("async_rst_done", longint'(done) | longint'(busy) | longint'(zero) | longint'(err), 0);
      @(negedge clk);
      rst = 1'b0;

      // Multiply with ignored starts during busy and on the finishing edge
      issue_op(4'd1, 8'd255, 8'd255);
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (n == 2 || n == W) begin
            start = 1'b1; opcode = 4'd0; a = 8'h11; b = 8'h22;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("mul_busy_cycles", n, W);
      check("mul_done", longint'(done), 1);
      check("mul_result", longint'(result), 16'hFE01);
      @(negedge clk);
      check("mul_no_extra_done", longint'(done), 0);
      check("mul_result_hold", longint'(result), 16'hFE01);

      issue_op(4'd2, 8'd7, 8'd7);
      check("sub_zero_result", longint'(result), 0);
      check("sub_zero_flag", longint'(zero), 1);
      issue_op(4'd2, 8'd5, 8'd7);
      check("sub_borrow", longint'(result), 16'h01FE);
      check("sub_borrow_zero", longint'(zero), 0);

      issue_op(4'd12, 8'd1, 8'd1);
      check("inv_done", longint'(done), 1);
      check("inv_err", longint'(err), 1);
      check("inv_hold", longint'(result), 16'h01FE);
      @(negedge clk);
      check("inv_err_persist", longint'(err), 1);
      issue_op(4'd11, 8'hAB, 8'hCD);
      check("cat_result", longint'(result), 16'hABCD);
      check("cat_err", longint'(err), 0);

      // Level-sampled start: back-to-back single-cycle ops
      @(negedge clk);
      start = 1'b1; opcode = 4'd0; a = 8'd1; b = 8'd2;
      @(negedge clk);
      check("b2b_done1", longint'(done), 1);
      check("b2b_result1", longint'(result), 3);
      opcode = 4'd5; a = 8'hF0; b = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      check("b2b_done2", longint'(done), 1);
      check("b2b_result2", longint'(result), 16'h00FF);

      for (int i = 0; i < 9; i++) begin
         issue_op(4'(i + 3), 8'hC3, 8'h5A);
         check($sformatf("vec_op%0d", i + 3), longint'(result), longint'(vec_exp[i]));
      end

      // Reset in the 4th multiply cycle abandons the operation
      issue_op(4'd1, 8'd255, 8'd255);
      repeat (3) @(negedge clk);
      check("mid_mul_busy", longint'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_result", longint'(result), 0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("mid_rst_no_done", dcount, 0);

      issue_op(4'd9, 8'h80, 8'h00);
      check("shl_result", longint'(result), 16'h0100);
      issue_op(4'd1, 8'd3, 8'd4);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("mul34_busy_cycles", n, W);
      check("mul34_done", longint'(done), 1);
      check("mul34_result", longint'(result), 12);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
   end

endmodule
